// File: rtl/cnn_pkg.sv
// cnn_pkg: state encoding and memory-map constants shared by the CNN layer sequencer and the arg-max readout
package cnn_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} argmax_state_t;
    localparam int CNN_WIDTH      = 16;
    localparam int CNN_DECIMAL    = 8;
    localparam int CNN_MEMADDRBIT = 20;
    localparam int FC2_OUTADDR    = 572414;
    localparam int FC2_NUM_CLASS  = 10;
endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: registered running-max unit (optional runner-up tracking under ARGMAX_TOP2_EN)
// Ports: clk, rst (sync active-low), en (sample valid), load_first (first sample of a run),
//        sample/idx in; max_score/max_idx out; second_score/second_idx out when ARGMAX_TOP2_EN is defined.
module argmax_cmp import cnn_pkg::*; #(
    parameter int WIDTH = CNN_WIDTH,
    parameter int IDXW  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load_first,
    input  logic signed [WIDTH-1:0] sample,
    input  logic        [IDXW-1:0]  idx,
    output logic signed [WIDTH-1:0] max_score,
    output logic        [IDXW-1:0]  max_idx
`ifdef ARGMAX_TOP2_EN
    ,
    output logic signed [WIDTH-1:0] second_score,
    output logic        [IDXW-1:0]  second_idx
`endif
);
    logic take;
    // strict compare keeps the lowest index on ties
    assign take = load_first || sample > max_score;
    always_ff @(posedge clk) begin
        if (!rst) begin
            max_score <= '0;
            max_idx   <= '0;
        end else if (en && take) begin
            max_score <= sample;
            max_idx   <= idx;
        end
    end
`ifdef ARGMAX_TOP2_EN
    logic second_vld;
    always_ff @(posedge clk) begin
        if (!rst) begin
            second_score <= '0;
            second_idx   <= '0;
            second_vld   <= 1'b0;
        end else if (en) begin
            if (load_first) begin
                second_score <= '0;
                second_idx   <= '0;
                second_vld   <= 1'b0;
            end else if (take) begin
                second_score <= max_score;
                second_idx   <= max_idx;
                second_vld   <= 1'b1;
            end else if (!second_vld || sample > second_score) begin
                second_score <= sample;
                second_idx   <= idx;
                second_vld   <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/cnn_argmax_readout.sv
// cnn_argmax_readout: scans the FC2 scores in BRAM after cnn_finish and presents the arg-max on valid/ready
// Ports: clk, rst (sync active-low), cnn_finish (start pulse), mem_rd_en/mem_rd_addr/mem_rd_data (BRAM read port),
//        busy, result_valid/result_ready (handshake), class_idx/class_score (result), overrun (start dropped in HOLD).
// Optional: ARGMAX_TOP2_EN adds second_idx/second_score (runner-up).
module cnn_argmax_readout import cnn_pkg::*; #(
    parameter int WIDTH      = CNN_WIDTH,
    parameter int DECIMAL    = CNN_DECIMAL,
    parameter int MEMADDRBIT = CNN_MEMADDRBIT,
    parameter int NUM_CLASS  = FC2_NUM_CLASS,
    parameter int BASE_ADDR  = FC2_OUTADDR,
    parameter int RD_LAT     = 1,
    parameter int IDXW       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnn_finish,
    output logic                  mem_rd_en,
    output logic [MEMADDRBIT-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]      mem_rd_data,
    output logic                  busy,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [IDXW-1:0]       class_idx,
    output logic [WIDTH-1:0]      class_score,
    output logic                  overrun
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [IDXW-1:0]       second_idx,
    output logic [WIDTH-1:0]      second_score
`endif
);
    localparam logic [IDXW-1:0] LAST = IDXW'(NUM_CLASS - 1);
    if (RD_LAT < 1 || RD_LAT > 2 || NUM_CLASS < 1 || DECIMAL >= WIDTH || (1 << IDXW) < NUM_CLASS) begin : g_cfg_bad
        $error("cnn_argmax_readout: unsupported parameter set");
    end
    argmax_state_t   state;
    logic [IDXW-1:0] cnt;
    logic            first;
    logic [RD_LAT-1:0] vld;
    logic [IDXW-1:0]   tag [RD_LAT];
    logic              tap;
    logic [IDXW-1:0]   tap_idx;
    assign tap     = vld[RD_LAT-1];
    assign tap_idx = tag[RD_LAT-1];
    assign busy    = state == ISSUE || state == DRAIN;
    // read-valid pipeline: each strobe carries its class index until its data returns
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) tag[i] <= '0;
        end else begin
            vld[0] <= mem_rd_en;
            tag[0] <= cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            first        <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_rd_addr  <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= state == HOLD && cnn_finish;
            if (tap) first <= 1'b0;
            case (state)
                IDLE: if (cnn_finish) begin
                    state       <= ISSUE;
                    cnt         <= '0;
                    first       <= 1'b1;
                    mem_rd_en   <= 1'b1;
                    mem_rd_addr <= MEMADDRBIT'(BASE_ADDR);
                end
                ISSUE: if (cnt == LAST) begin
                    state     <= DRAIN;
                    mem_rd_en <= 1'b0;
                end else begin
                    cnt         <= cnt + 1'b1;
                    mem_rd_addr <= mem_rd_addr + 1'b1;
                end
                // the running max updates on this same edge, so valid rises with the final result
                DRAIN: if (tap && tap_idx == LAST) begin
                    state        <= HOLD;
                    result_valid <= 1'b1;
                end
                HOLD: if (result_ready) begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    argmax_cmp #(.WIDTH(WIDTH), .IDXW(IDXW)) u_cmp (
        .clk         (clk),
        .rst         (rst),
        .en          (tap),
        .load_first  (first),
        .sample      (mem_rd_data),
        .idx         (tap_idx),
        .max_score   (class_score),
        .max_idx     (class_idx)
`ifdef ARGMAX_TOP2_EN
        ,
        .second_score(second_score),
        .second_idx  (second_idx)
`endif
    );
endmodule

// File: tb/tb_cnn_argmax_readout.sv
// tb_cnn_argmax_readout: directed self-checking bench for the arg-max readout (RD_LAT=1 and RD_LAT=2 instances)
module tb_cnn_argmax_readout;
    localparam int BASE = 572414;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cnn_finish = 1'b0;
    logic result_ready = 1'b0;
    logic        en1, busy1, rv1, ovr1, en2, busy2, rv2, ovr2;
    logic [19:0] addr1, addr2;
    logic [15:0] d1, d2a, d2b, score1, score2;
    logic [3:0]  idx1, idx2;
`ifdef ARGMAX_TOP2_EN
    logic [3:0]  sidx1, sidx2;
    logic [15:0] sscore1, sscore2;
`endif
    logic [15:0] mem [10];
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    cnn_argmax_readout #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .cnn_finish(cnn_finish),
        .mem_rd_en(en1), .mem_rd_addr(addr1), .mem_rd_data(d1),
        .busy(busy1), .result_valid(rv1), .result_ready(result_ready),
        .class_idx(idx1), .class_score(score1), .overrun(ovr1)
`ifdef ARGMAX_TOP2_EN
        , .second_idx(sidx1), .second_score(sscore1)
`endif
    );
    cnn_argmax_readout #(.RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .cnn_finish(cnn_finish),
        .mem_rd_en(en2), .mem_rd_addr(addr2), .mem_rd_data(d2b),
        .busy(busy2), .result_valid(rv2), .result_ready(result_ready),
        .class_idx(idx2), .class_score(score2), .overrun(ovr2)
`ifdef ARGMAX_TOP2_EN
        , .second_idx(sidx2), .second_score(sscore2)
`endif
    );
    always @(posedge clk) begin
        if (en1) d1 <= mem[int'(addr1) - BASE];
        if (en2) d2a <= mem[int'(addr2) - BASE];
        d2b <= d2a;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic load(input logic [159:0] p);
        for (int i = 0; i < 10; i++) mem[i] = p[159-16*i -: 16];
    endtask
    task automatic start();
        @(negedge clk);
        cnn_finish = 1'b1;
        @(posedge clk);
        #1;
        cnn_finish = 1'b0;
    endtask
    task automatic wait_valid(input string tag);
        int k = 0;
        while (!rv1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, rv1, 1);
    endtask
    localparam logic [159:0] S1 = {16'h0003, 16'hFFFB, 16'h0180, 16'h0007, 16'h0100,
                                   16'hFFFF, 16'h0000, 16'h0002, 16'h017F, 16'h0004};
    localparam logic [159:0] S3 = {16'h8000, 16'hFF00, 16'hFFE0, 16'hC000, 16'hFFEF,
                                   16'h8001, 16'hF000, 16'hFFE1, 16'hFFEF, 16'hFFF0};
    initial begin
        logic saw;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", en1, 0);
        chk("rst_addr", addr1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_valid", rv1, 0);
        chk("rst_idx", idx1, 0);
        chk("rst_score", score1, 0);
        chk("rst_overrun", ovr1, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        // scenario 1: mixed scores, cycle-exact timing
        load(S1);
        result_ready = 1'b1;
        start();
        chk("s1_en0", en1, 1);
        chk("s1_addr0", addr1, BASE);
        chk("s1_busy0", busy1, 1);
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("s1_en", en1, 1);
            chk("s1_addr", addr1, BASE + i);
        end
        @(posedge clk);
        #1;
        chk("s1_en_off", en1, 0);
        chk("s1_drain_valid", rv1, 0);
        chk("s1_drain_busy", busy1, 1);
        @(posedge clk);
        #1;
        chk("s1_valid", rv1, 1);
        chk("s1_idx", idx1, 2);
        chk("s1_score", score1, 16'h0180);
        chk("s1_busy_low", busy1, 0);
        chk("s1_lat2_not_yet", rv2, 0);
`ifdef ARGMAX_TOP2_EN
        chk("s1_second_idx", sidx1, 8);
        chk("s1_second_score", sscore1, 16'h017F);
`endif
        @(posedge clk);
        #1;
        chk("s1_valid_drop", rv1, 0);
        chk("s1_idx_held", idx1, 2);
        chk("s1_score_held", score1, 16'h0180);
        chk("s1_lat2_valid", rv2, 1);
        chk("s1_lat2_idx", idx2, 2);
        chk("s1_lat2_score", score2, 16'h0180);
        @(posedge clk);
        #1;
        chk("s1_lat2_drop", rv2, 0);
        repeat (4) @(posedge clk);
        // scenario 2: all ties keep index 0
        load({10{16'hFF00}});
        start();
        wait_valid("s2_valid");
        chk("s2_idx", idx1, 0);
        chk("s2_score", score1, 16'hFF00);
`ifdef ARGMAX_TOP2_EN
        chk("s2_second_idx", sidx1, 1);
`endif
        repeat (4) @(posedge clk);
        // scenario 3: all negative, max at the last index
        load(S3);
        start();
        wait_valid("s3_valid");
        chk("s3_idx", idx1, 9);
        chk("s3_score", score1, 16'hFFF0);
        repeat (4) @(posedge clk);
        // scenario 4: hold under back-pressure, overrun on dropped start
        result_ready = 1'b0;
        load(S1);
        start();
        wait_valid("s4_valid");
        saw = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            saw |= en1;
        end
        chk("s4_hold_valid", rv1, 1);
        chk("s4_hold_idx", idx1, 2);
        @(negedge clk);
        cnn_finish = 1'b1;
        @(posedge clk);
        #1;
        cnn_finish = 1'b0;
        chk("s4_overrun", ovr1, 1);
        chk("s4_overrun_valid", rv1, 1);
        @(posedge clk);
        #1;
        chk("s4_overrun_pulse", ovr1, 0);
        repeat (14) begin
            @(posedge clk);
            #1;
            saw |= en1;
        end
        chk("s4_no_strobes", saw, 0);
        chk("s4_still_valid", rv1, 1);
        chk("s4_still_score", score1, 16'h0180);
        @(negedge clk);
        result_ready = 1'b1;
        cnn_finish = 1'b1;
        @(posedge clk);
        #1;
        cnn_finish = 1'b0;
        chk("s4_accept_drop", rv1, 0);
        chk("s4_accept_overrun", ovr1, 1);
        chk("s4_no_restart", en1, 0);
        @(posedge clk);
        #1;
        chk("s4_idle_en", en1, 0);
        chk("s4_idle_busy", busy1, 0);
        repeat (3) @(posedge clk);
        // scenario 5: reset mid-ISSUE abandons the run
        start();
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("s5_rst_en", en1, 0);
        chk("s5_rst_busy", busy1, 0);
        chk("s5_rst_idx", idx1, 0);
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            saw |= rv1 | en1;
        end
        chk("s5_no_valid", saw, 0);
        load(S3);
        start();
        wait_valid("s5_valid");
        chk("s5_idx", idx1, 9);
        chk("s5_score", score1, 16'hFFF0);
        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
